alu_issue_stage: RTL and testbench

Operand-fetch, issue and writeback stage that feeds the 8-bit ALU and consumes its result.
- Holds the 8x8 register file and the Z/C flags register.
- Decodes a 16-bit instruction and registers operands into an execute (EX) latch that drives the ALU combinationally.
- On the following edge, writes the ALU result back to the register file and flags.
- Forwards the in-flight EX result to a dependent next instruction, so back-to-back issue never stalls.

---
 rtl/alu_issue_stage.sv | 122 ++++++++++++
 tb/tb_alu_issue_stage.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// alu_issue_stage
//   Operand-fetch, issue and writeback stage in front of an external 8-bit ALU.
//   Holds the register file (r0 reads as zero) and the Z/C flags. An accepted
//   instruction is latched into EX, which drives the ALU combinationally; the
//   ALU result is committed on the following edge. The in-flight EX result is
//   forwarded to the next instruction, so back-to-back issue never stalls.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   instr, instr_valid       instruction in: op[15:13] rd[12:10] ra[9:7]
//                            imm_en[6] rb[5:3] / imm[5:0]
//   instr_ready              stage accepts this cycle (= !hold)
//   hold                     freezes acceptance, EX and writeback
//   alu_a, alu_b, alu_op     EX latch, drives the ALU
//   alu_out, alu_zero,
//   alu_carry                ALU result
//   ret_valid, ret_rd,
//   ret_data                 registered one-cycle retire pulse and its payload
//   flag_z, flag_c           architectural flags
//   dbg_addr, dbg_data       combinational register-file read port
module alu_issue_stage #(
    parameter int DATA_W = 8,
    parameter int NREG   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       instr,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic              hold,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_op,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_zero,
    input  logic              alu_carry,
    output logic              ret_valid,
    output logic [2:0]        ret_rd,
    output logic [DATA_W-1:0] ret_data,
    output logic              flag_z,
    output logic              flag_c,
    input  logic [2:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    logic [DATA_W-1:0] rf [NREG];

    logic              ex_valid;
    logic [2:0]        ex_rd;

    logic [2:0]        f_rd, f_ra, f_rb, f_op;
    logic              f_imm_en;
    logic [DATA_W-1:0] f_imm;
    logic [DATA_W-1:0] src_a, src_b, nxt_b;
    logic              fire;

    assign f_op     = instr[15:13];
    assign f_rd     = instr[12:10];
    assign f_ra     = instr[9:7];
    assign f_imm_en = instr[6];
    assign f_rb     = instr[5:3];
    assign f_imm    = {{(DATA_W-6){1'b0}}, instr[5:0]};

    assign instr_ready = !hold;
    assign fire        = instr_valid && !hold;

    // Operand read with forwarding from the EX result. A nonzero match on
    // ex_rd implies ex_rd != 0, so r0 is never forwarded.
    always_comb begin
        src_a = '0;
        src_b = '0;
        if (f_ra != 3'd0)
            src_a = (ex_valid && ex_rd == f_ra) ? alu_out : rf[f_ra];
        if (f_rb != 3'd0)
            src_b = (ex_valid && ex_rd == f_rb) ? alu_out : rf[f_rb];
        nxt_b = f_imm_en ? f_imm : src_b;
    end

    assign dbg_data = (dbg_addr == 3'd0) ? '0 : rf[dbg_addr];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREG; i++)
                rf[i] <= '0;
            ex_valid  <= 1'b0;
            ex_rd     <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
            flag_z    <= 1'b0;
            flag_c    <= 1'b0;
            ret_valid <= 1'b0;
            ret_rd    <= '0;
            ret_data  <= '0;
        end else if (hold) begin
            ret_valid <= 1'b0;
        end else begin
            if (ex_valid) begin
                if (ex_rd != 3'd0)
                    rf[ex_rd] <= alu_out;
                flag_z    <= alu_zero;
                flag_c    <= alu_carry;
                ret_valid <= 1'b1;
                ret_rd    <= ex_rd;
                ret_data  <= alu_out;
            end else begin
                ret_valid <= 1'b0;
            end

            if (fire) begin
                ex_valid <= 1'b1;
                ex_rd    <= f_rd;
                alu_op   <= f_op;
                alu_a    <= src_a;
                alu_b    <= nxt_b;
            end else begin
                ex_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage
//   Bench for alu_issue_stage. The bench supplies the ALU (ADD, SUB, AND, OR,
//   XOR, NOT, SHL, SHR) and an architectural reference model that executes each
//   accepted instruction in program order and retires it one unheld edge later.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] instr = '0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic        hold = 1'b0;
    logic [7:0]  alu_a, alu_b, alu_out;
    logic [2:0]  alu_op;
    logic        alu_zero, alu_carry;
    logic        ret_valid;
    logic [2:0]  ret_rd;
    logic [7:0]  ret_data;
    logic        flag_z, flag_c;
    logic [2:0]  dbg_addr = '0;
    logic [7:0]  dbg_data;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_issue_stage #(.DATA_W(8), .NREG(8)) dut (
        .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .hold(hold),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_out(alu_out), .alu_zero(alu_zero), .alu_carry(alu_carry),
        .ret_valid(ret_valid), .ret_rd(ret_rd), .ret_data(ret_data),
        .flag_z(flag_z), .flag_c(flag_c),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    // Bench-side ALU: returns {carry, result}.
    function automatic logic [8:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd0: return {1'b0, a} + {1'b0, b};
            3'd1: return {1'b0, a} - {1'b0, b};
            3'd2: return {1'b0, a & b};
            3'd3: return {1'b0, a | b};
            3'd4: return {1'b0, a ^ b};
            3'd5: return {1'b0, ~a};
            3'd6: return {a, 1'b0};
            default: return {a[0], 1'b0, a[7:1]};
        endcase
    endfunction

    always_comb begin
        {alu_carry, alu_out} = alu_f(alu_op, alu_a, alu_b);
        alu_zero = (alu_out == 8'h00);
    end

    // Architectural model: committed registers/flags, one pending result,
    // and the expected retire outputs.
    int         mrf [8];
    logic       p_v = 1'b0;
    logic [2:0] p_rd;
    logic [7:0] p_data;
    logic       p_z, p_c;
    logic       e_ret_v = 1'b0;
    logic [2:0] e_ret_rd = '0;
    logic [7:0] e_ret_data = '0;
    logic       e_z = 1'b0, e_c = 1'b0;

    task automatic tick(input logic [15:0] i, input logic v, input logic h, input logic r);
        logic [7:0] a, b;
        logic [8:0] res;
        instr = i; instr_valid = v; hold = h; rst = r;
        @(posedge clk);
        if (r) begin
            for (int k = 0; k < 8; k++) mrf[k] = 0;
            p_v = 1'b0; e_ret_v = 1'b0; e_ret_rd = '0; e_ret_data = '0;
            e_z = 1'b0; e_c = 1'b0;
        end else if (h) begin
            e_ret_v = 1'b0;
        end else begin
            e_ret_v = p_v;
            if (p_v) begin
                if (p_rd != 0) mrf[p_rd] = int'(p_data);
                e_z = p_z; e_c = p_c; e_ret_rd = p_rd; e_ret_data = p_data;
            end
            if (v) begin
                a = (i[9:7] == 0) ? 8'h00 : 8'(mrf[i[9:7]]);
                b = i[6] ? {2'b00, i[5:0]} : ((i[5:3] == 0) ? 8'h00 : 8'(mrf[i[5:3]]));
                res = alu_f(i[15:13], a, b);
                p_v = 1'b1; p_rd = i[12:10]; p_data = res[7:0];
                p_c = res[8]; p_z = (res[7:0] == 8'h00);
            end else begin
                p_v = 1'b0;
            end
        end
        #1;
    endtask

    task automatic test_reset;
        tick(16'h0000, 1'b0, 1'b0, 1'b1);
        n_cmp++; if (ret_valid !== 1'b0) begin n_bad++; $display("FAIL reset_ret_valid got=%0d want=0", ret_valid); end
        n_cmp++; if (ret_rd !== 3'd0 || ret_data !== 8'h00) begin n_bad++; $display("FAIL reset_ret got rd=%0d data=%h want 0/00", ret_rd, ret_data); end
        n_cmp++; if (flag_z !== 1'b0 || flag_c !== 1'b0) begin n_bad++; $display("FAIL reset_flags got z=%0d c=%0d want 0/0", flag_z, flag_c); end
        n_cmp++; if (alu_a !== 8'h00 || alu_b !== 8'h00 || alu_op !== 3'd0) begin n_bad++; $display("FAIL reset_ex got a=%h b=%h op=%0d want 0", alu_a, alu_b, alu_op); end
        n_cmp++; if (instr_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got=%0d want=1", instr_ready); end
        for (int k = 0; k < 8; k++) begin
            dbg_addr = 3'(k); #1;
            n_cmp++; if (dbg_data !== 8'h00) begin n_bad++; $display("FAIL reset_rf r%0d got=%h want=00", k, dbg_data); end
        end
    endtask

    task automatic test_addi;
        tick(16'h0000, 1'b0, 1'b0, 1'b1);
        tick(16'h0445, 1'b1, 1'b0, 1'b0);
        n_cmp++; if (ret_valid !== 1'b0) begin n_bad++; $display("FAIL addi_early_ret got=%0d want=0", ret_valid); end
        tick(16'h0000, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (ret_valid !== 1'b1 || ret_rd !== 3'd1 || ret_data !== 8'h05) begin n_bad++; $display("FAIL addi_ret got v=%0d rd=%0d data=%h want 1/1/05", ret_valid, ret_rd, ret_data); end
        dbg_addr = 3'd1; #1;
        n_cmp++; if (dbg_data !== 8'h05) begin n_bad++; $display("FAIL addi_r1 got=%h want=05", dbg_data); end
        n_cmp++; if (flag_z !== 1'b0 || flag_c !== 1'b0) begin n_bad++; $display("FAIL addi_flags got z=%0d c=%0d want 0/0", flag_z, flag_c); end
        tick(16'h0000, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (ret_valid !== 1'b0 || ret_data !== 8'h05) begin n_bad++; $display("FAIL addi_drain got v=%0d data=%h want 0/05", ret_valid, ret_data); end
    endtask

    task automatic test_back_to_back;
        tick(16'h0000, 1'b0, 1'b0, 1'b1);
        tick(16'h0445, 1'b1, 1'b0, 1'b0);
        n_cmp++; if (instr_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready0 got=%0d want=1", instr_ready); end
        tick(16'h0888, 1'b1, 1'b0, 1'b0);
        n_cmp++; if (ret_valid !== 1'b1 || ret_data !== 8'h05) begin n_bad++; $display("FAIL b2b_ret0 got v=%0d data=%h want 1/05", ret_valid, ret_data); end
        n_cmp++; if (instr_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready1 got=%0d want=1", instr_ready); end
        tick(16'h0000, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (ret_valid !== 1'b1 || ret_rd !== 3'd2 || ret_data !== 8'h0A) begin n_bad++; $display("FAIL b2b_ret1 got v=%0d rd=%0d data=%h want 1/2/0a", ret_valid, ret_rd, ret_data); end
        dbg_addr = 3'd2; #1;
        n_cmp++; if (dbg_data !== 8'h0A) begin n_bad++; $display("FAIL b2b_r2 got=%h want=0a", dbg_data); end
    endtask

    task automatic test_not_inc;
        tick(16'hAC00, 1'b1, 1'b0, 1'b0);
        tick(16'h11C1, 1'b1, 1'b0, 1'b0);
        n_cmp++; if (ret_rd !== 3'd3 || ret_data !== 8'hFF) begin n_bad++; $display("FAIL not_ret got rd=%0d data=%h want 3/ff", ret_rd, ret_data); end
        tick(16'h0000, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (ret_valid !== 1'b1 || ret_rd !== 3'd4 || ret_data !== 8'h00) begin n_bad++; $display("FAIL inc_ret got v=%0d rd=%0d data=%h want 1/4/00", ret_valid, ret_rd, ret_data); end
        n_cmp++; if (flag_z !== 1'b1 || flag_c !== 1'b1) begin n_bad++; $display("FAIL inc_flags got z=%0d c=%0d want 1/1", flag_z, flag_c); end
        dbg_addr = 3'd3; #1;
        n_cmp++; if (dbg_data !== 8'hFF) begin n_bad++; $display("FAIL not_r3 got=%h want=ff", dbg_data); end
    endtask

    task automatic test_r0;
        tick(16'h0047, 1'b1, 1'b0, 1'b0);
        tick(16'h1400, 1'b1, 1'b0, 1'b0);
        n_cmp++; if (ret_valid !== 1'b1 || ret_rd !== 3'd0 || ret_data !== 8'h07) begin n_bad++; $display("FAIL r0_ret got v=%0d rd=%0d data=%h want 1/0/07", ret_valid, ret_rd, ret_data); end
        tick(16'h0000, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (ret_rd !== 3'd5 || ret_data !== 8'h00) begin n_bad++; $display("FAIL r0_fwd got rd=%0d data=%h want 5/00", ret_rd, ret_data); end
        dbg_addr = 3'd0; #1;
        n_cmp++; if (dbg_data !== 8'h00) begin n_bad++; $display("FAIL r0_read got=%h want=00", dbg_data); end
    endtask

    task automatic test_hold;
        tick(16'h0000, 1'b0, 1'b0, 1'b1);
        tick(16'h0445, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick(16'h0888, 1'b1, 1'b1, 1'b0);
            n_cmp++; if (ret_valid !== 1'b0) begin n_bad++; $display("FAIL hold_ret c%0d got=%0d want=0", k, ret_valid); end
            n_cmp++; if (alu_a !== 8'h00 || alu_b !== 8'h05 || alu_op !== 3'd0) begin n_bad++; $display("FAIL hold_ex c%0d got a=%h b=%h op=%0d want 00/05/0", k, alu_a, alu_b, alu_op); end
            n_cmp++; if (instr_ready !== 1'b0) begin n_bad++; $display("FAIL hold_ready c%0d got=%0d want=0", k, instr_ready); end
        end
        tick(16'h0000, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (ret_valid !== 1'b1 || ret_rd !== 3'd1 || ret_data !== 8'h05) begin n_bad++; $display("FAIL hold_release got v=%0d rd=%0d data=%h want 1/1/05", ret_valid, ret_rd, ret_data); end
        tick(16'h0000, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (ret_valid !== 1'b0) begin n_bad++; $display("FAIL hold_single got=%0d want=0", ret_valid); end
        dbg_addr = 3'd2; #1;
        n_cmp++; if (dbg_data !== 8'h00) begin n_bad++; $display("FAIL hold_noaccept r2 got=%h want=00", dbg_data); end
    endtask

    task automatic test_reset_inflight;
        tick(16'h0000, 1'b0, 1'b0, 1'b1);
        tick(16'h0445, 1'b1, 1'b0, 1'b0);
        tick(16'h0000, 1'b0, 1'b0, 1'b1);
        n_cmp++; if (ret_valid !== 1'b0) begin n_bad++; $display("FAIL rstfl_ret got=%0d want=0", ret_valid); end
        tick(16'h0000, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (ret_valid !== 1'b0) begin n_bad++; $display("FAIL rstfl_noretire got=%0d want=0", ret_valid); end
        dbg_addr = 3'd1; #1;
        n_cmp++; if (dbg_data !== 8'h00) begin n_bad++; $display("FAIL rstfl_r1 got=%h want=00", dbg_data); end
        n_cmp++; if (flag_z !== 1'b0 || flag_c !== 1'b0) begin n_bad++; $display("FAIL rstfl_flags got z=%0d c=%0d want 0/0", flag_z, flag_c); end
    endtask

    task automatic test_random;
        logic [15:0] i;
        logic v, h, r;
        for (int n = 0; n < 400; n++) begin
            i = 16'($urandom);
            v = ($urandom_range(0, 9) < 8);
            h = ($urandom_range(0, 9) < 2);
            r = ($urandom_range(0, 99) < 2);
            tick(i, v, h, r);
            n_cmp++; if (ret_valid !== e_ret_v) begin n_bad++; $display("FAIL rnd_ret_valid n=%0d got=%0d want=%0d", n, ret_valid, e_ret_v); end
            n_cmp++; if (ret_rd !== e_ret_rd || ret_data !== e_ret_data) begin n_bad++; $display("FAIL rnd_ret n=%0d got rd=%0d data=%h want %0d/%h", n, ret_rd, ret_data, e_ret_rd, e_ret_data); end
            n_cmp++; if (flag_z !== e_z || flag_c !== e_c) begin n_bad++; $display("FAIL rnd_flags n=%0d got z=%0d c=%0d want %0d/%0d", n, flag_z, flag_c, e_z, e_c); end
            n_cmp++; if (instr_ready !== !h) begin n_bad++; $display("FAIL rnd_ready n=%0d got=%0d want=%0d", n, instr_ready, !h); end
            dbg_addr = 3'($urandom_range(0, 7)); #1;
            n_cmp++; if (dbg_data !== 8'(mrf[dbg_addr])) begin n_bad++; $display("FAIL rnd_rf n=%0d r%0d got=%h want=%h", n, dbg_addr, dbg_data, 8'(mrf[dbg_addr])); end
        end
    endtask

    initial begin
        test_reset;
        test_addi;
        test_back_to_back;
        test_not_inc;
        test_r0;
        test_hold;
        test_reset_inflight;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
